// File: rtl/rtc_multi_timer.sv
// Multi-channel BCD hh:mm:ss countdown timer with per-channel reload and expiry interrupt.
// One rtc_multi_timer_chan per channel; the top decodes writes and registers the read port.
module rtc_multi_timer_chan #(
  parameter int LGSUBCK = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_sub_ck,
  input  logic        i_wr,
  input  logic [25:0] i_data,
  output logic [23:0] o_timer,
  output logic        o_running,
  output logic        o_reload_en,
  output logic        o_alarm,
  output logic        o_int
);
  logic [23:0]        timer_q, timer_d, reload_q, reload_d, wr_time;
  logic [LGSUBCK-1:0] sub_q, sub_d;
  logic               running_q, running_d, reload_en_q, reload_en_d;
  logic               alarm_q, alarm_d, int_q, int_d;
  logic               tick, expire;

  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[6:4] != 3'd0) r[6:4] = t[6:4] - 3'd1;
      else begin
        r[6:4] = 3'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (t[14:12] != 3'd0) r[14:12] = t[14:12] - 3'd1;
          else begin
            r[14:12] = 3'd5;
            if (t[19:16] != 4'd0) r[19:16] = t[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = t[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // bits 7 and 15 are padding in the BCD layout and never stored
  assign wr_time = i_data[23:0] & 24'hFF7F7F;
  assign tick    = running_q && i_sub_ck && (&sub_q);

  always_comb begin
    timer_d     = timer_q;
    reload_d    = reload_q;
    sub_d       = sub_q;
    running_d   = running_q;
    reload_en_d = reload_en_q;
    alarm_d     = alarm_q;
    expire      = 1'b0;
    if (running_q && i_sub_ck) sub_d = sub_q + 1'b1;
    if (tick) begin
      if (timer_q == 24'h000001) begin
        expire  = 1'b1;
        alarm_d = 1'b1;
        if (reload_en_q) timer_d = reload_q;
        else begin
          timer_d   = '0;
          running_d = 1'b0;
        end
      end else begin
        timer_d = bcd_dec(timer_q);
      end
    end
    if (i_wr) begin
      if (running_q) begin
        // a non-reloading expiry in the same cycle wins over the run bit
        running_d   = i_data[24] && !(expire && !reload_en_q);
        reload_en_d = i_data[25];
        if (!expire) alarm_d = 1'b0;
      end else if (wr_time != 24'h0) begin
        timer_d     = wr_time;
        reload_d    = wr_time;
        sub_d       = '0;
        alarm_d     = 1'b0;
        running_d   = i_data[24];
        reload_en_d = i_data[25];
      end else begin
        alarm_d     = 1'b0;
        reload_en_d = i_data[25];
        running_d   = i_data[24] && (timer_q != 24'h0);
      end
    end
    int_d = expire;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer_q     <= '0;
      reload_q    <= '0;
      sub_q       <= '0;
      running_q   <= 1'b0;
      reload_en_q <= 1'b0;
      alarm_q     <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      reload_q    <= reload_d;
      sub_q       <= sub_d;
      running_q   <= running_d;
      reload_en_q <= reload_en_d;
      alarm_q     <= alarm_d;
      int_q       <= int_d;
    end
  end

  assign o_timer     = timer_q;
  assign o_running   = running_q;
  assign o_reload_en = reload_en_q;
  assign o_alarm     = alarm_q;
  assign o_int       = int_q;
endmodule

module rtc_multi_timer #(
  parameter int NCHAN   = 4,
  parameter int LGSUBCK = 2,
  parameter int LGCH    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sub_ck,
  input  logic             i_wr,
  input  logic [LGCH-1:0]  i_addr,
  input  logic [25:0]      i_data,
  output logic [31:0]      o_data,
  output logic [NCHAN-1:0] o_interrupt
);
  logic [NCHAN-1:0][23:0] tmr;
  logic [NCHAN-1:0]       run, rle, alm;
  logic [31:0]            o_data_q, o_data_d;
  logic                   bcd_ok, wr_ok;

  assign bcd_ok = (i_data[3:0]   <= 4'd9) && (i_data[6:4]   <= 3'd5) &&
                  (i_data[11:8]  <= 4'd9) && (i_data[14:12] <= 3'd5) &&
                  (i_data[19:16] <= 4'd9) && (i_data[23:20] <= 4'd9);
  assign wr_ok  = i_wr && bcd_ok;

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    rtc_multi_timer_chan #(.LGSUBCK(LGSUBCK)) u_ch (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_sub_ck    (i_sub_ck),
      .i_wr        (wr_ok && (i_addr == LGCH'(c))),
      .i_data      (i_data),
      .o_timer     (tmr[c]),
      .o_running   (run[c]),
      .o_reload_en (rle[c]),
      .o_alarm     (alm[c]),
      .o_int       (o_interrupt[c])
    );
  end

  // addresses beyond NCHAN match no channel and read back zero
  always_comb begin
    o_data_d = '0;
    for (int c = 0; c < NCHAN; c++)
      if (i_addr == LGCH'(c)) o_data_d = {6'h0, rle[c], alm[c], run[c], tmr[c]};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_data_q <= '0;
    else            o_data_q <= o_data_d;
  end

  assign o_data = o_data_q;
endmodule

// File: tb/tb_rtc_multi_timer.sv
// Randomized + scenario bench for rtc_multi_timer against a seconds-based reference model.
module tb_rtc_multi_timer;
  localparam int NCHAN = 4, LGSUBCK = 2, LGCH = 2, NSUB = 4;

  logic             i_clk = 1'b0, i_reset_n = 1'b0, i_sub_ck = 1'b0, i_wr = 1'b0;
  logic [LGCH-1:0]  i_addr = '0;
  logic [25:0]      i_data = '0;
  logic [31:0]      o_data;
  logic [NCHAN-1:0] o_interrupt;

  always #5 i_clk = ~i_clk;

  rtc_multi_timer #(.NCHAN(NCHAN), .LGSUBCK(LGSUBCK), .LGCH(LGCH)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sub_ck(i_sub_ck), .i_wr(i_wr),
    .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .o_interrupt(o_interrupt)
  );

  int n_tests = 0, n_fail = 0, clk_cnt = 0;
  int m_secs[NCHAN], m_rld[NCHAN], m_sub[NCHAN], int_cnt[NCHAN], obs_cnt[NCHAN];
  bit m_run[NCHAN], m_rle[NCHAN], m_alm[NCHAN];
  logic [31:0]      exp_data;
  logic [NCHAN-1:0] exp_int;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] sec2bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 1'b0, 3'(m / 10), 4'(m % 10), 1'b0, 3'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int bcd2sec(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
           (int'(b[14:12]) * 10 + int'(b[11:8])) * 60 +
           (int'(b[6:4]) * 10 + int'(b[3:0]));
  endfunction

  function automatic bit bcd_valid(input logic [23:0] b);
    int dig[6], lim[6];
    dig = '{int'(b[3:0]), int'(b[6:4]), int'(b[11:8]), int'(b[14:12]), int'(b[19:16]), int'(b[23:20])};
    lim = '{9, 5, 9, 5, 9, 9};
    for (int k = 0; k < 6; k++) if (dig[k] > lim[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      m_secs[c] = 0; m_rld[c] = 0; m_sub[c] = 0;
      m_run[c] = 0; m_rle[c] = 0; m_alm[c] = 0;
    end
    exp_data = '0; exp_int = '0;
  endtask

  // advances the model by one clock edge using the inputs held across that edge
  task automatic model_step();
    bit orun, orle, fire, wv;
    int a;
    if (!i_reset_n) begin model_reset(); return; end
    a = int'(i_addr);
    exp_data = {6'h0, m_rle[a], m_alm[a], m_run[a], sec2bcd(m_secs[a])};
    exp_int = '0;
    for (int c = 0; c < NCHAN; c++) begin
      orun = m_run[c]; orle = m_rle[c]; fire = 0;
      wv = i_wr && (a == c) && bcd_valid(i_data[23:0]);
      if (orun && i_sub_ck) begin
        if (m_sub[c] == NSUB - 1) begin
          if (m_secs[c] == 1) begin
            fire = 1; m_alm[c] = 1;
            if (orle) m_secs[c] = m_rld[c];
            else begin m_secs[c] = 0; m_run[c] = 0; end
          end else m_secs[c] = m_secs[c] - 1;
        end
        m_sub[c] = (m_sub[c] + 1) % NSUB;
      end
      if (wv) begin
        if (orun) begin
          m_rle[c] = i_data[25];
          m_run[c] = (fire && !orle) ? 1'b0 : i_data[24];
          if (!fire) m_alm[c] = 0;
        end else if (bcd2sec(i_data[23:0]) != 0) begin
          m_secs[c] = bcd2sec(i_data[23:0]); m_rld[c] = m_secs[c];
          m_sub[c] = 0; m_alm[c] = 0; m_run[c] = i_data[24]; m_rle[c] = i_data[25];
        end else begin
          m_alm[c] = 0; m_rle[c] = i_data[25];
          m_run[c] = i_data[24] && (m_secs[c] != 0);
        end
      end
      exp_int[c] = fire;
      if (fire) int_cnt[c]++;
    end
  endtask

  task automatic cyc(input bit wr, input logic [LGCH-1:0] a, input logic [25:0] d);
    i_wr = wr; i_addr = a; i_data = d; i_sub_ck = (clk_cnt % 3 == 2);
    @(posedge i_clk);
    model_step();
    clk_cnt++;
    #1;
    chk("o_data", o_data, exp_data);
    chk("o_interrupt", 32'(o_interrupt), 32'(exp_int));
    for (int c = 0; c < NCHAN; c++) obs_cnt[c] += int'(o_interrupt[c]);
  endtask

  task automatic idle(input int n, input logic [LGCH-1:0] a);
    repeat (n) cyc(1'b0, a, 26'h0);
  endtask

  initial begin
    int s0, s1, e1;
    logic [25:0] d;
    model_reset();
    for (int c = 0; c < NCHAN; c++) begin int_cnt[c] = 0; obs_cnt[c] = 0; end
    #1;
    chk("reset_data", o_data, 32'h0);
    chk("reset_int", 32'(o_interrupt), 32'h0);
    idle(2, 0);
    i_reset_n = 1'b1;
    idle(2, 0);

    // one-shot expiry on ch0
    s0 = obs_cnt[0];
    cyc(1'b1, 2'd0, 26'h1000002);
    idle(30, 0);
    chk("oneshot_pulses", 32'(obs_cnt[0] - s0), 32'd1);
    chk("oneshot_state", o_data, 32'h0200_0000);

    // auto-reload on ch1
    s1 = obs_cnt[1]; e1 = int_cnt[1];
    cyc(1'b1, 2'd1, 26'h3000002);
    idle(100, 1);
    chk("reload_pulses", 32'(obs_cnt[1] - s1), 32'(int_cnt[1] - e1));
    chk("reload_min_pulses", 32'(obs_cnt[1] - s1 >= 3), 32'd1);
    chk("reload_running", 32'(o_data[24]), 32'd1);

    // stop and resume ch3
    cyc(1'b1, 2'd3, 26'h1000005);
    cyc(1'b0, 2'd3, 26'h0);
    cyc(1'b1, 2'd3, 26'h0000000);
    idle(20, 3);
    chk("stop_hold_timer", 32'(o_data[23:0]), 32'h5);
    chk("stop_hold_run", 32'(o_data[24]), 32'd0);
    cyc(1'b1, 2'd3, 26'h1000000);
    idle(60, 3);

    // malformed BCD writes to stopped ch0 are dropped
    cyc(1'b1, 2'd0, 26'h1000060);
    cyc(1'b1, 2'd0, 26'h10A0000);
    idle(3, 0);
    chk("bad_bcd_state", o_data, 32'h0200_0000);

    // hour borrow on ch2, then full hour to expiry
    s0 = obs_cnt[2];
    cyc(1'b1, 2'd2, 26'h1010000);
    idle(14, 2);
    chk("borrow_005959", 32'(o_data[23:0]), 32'h005959);
    idle(3600 * 12 + 20, 2);
    chk("hour_pulses", 32'(obs_cnt[2] - s0), 32'd1);
    chk("hour_end", o_data, 32'h0200_0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0:       d = 26'($urandom);
        1:       d = {2'($urandom), 24'h0};
        default: d = {2'($urandom), sec2bcd(int'($urandom % 12))};
      endcase
      cyc(($urandom % 4) == 0, 2'($urandom), d);
    end

    // async reset mid-count on all channels
    for (int c = 0; c < NCHAN; c++) cyc(1'b1, 2'(c), 26'h3000003);
    idle(10, 0);
    for (int c = 0; c < NCHAN; c++) s1 = obs_cnt[c];
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_data", o_data, 32'h0);
    chk("async_reset_int", 32'(o_interrupt), 32'h0);
    idle(2, 1);
    i_reset_n = 1'b1;
    s0 = 0;
    for (int c = 0; c < NCHAN; c++) s0 += obs_cnt[c];
    for (int c = 0; c < NCHAN; c++) idle(20, 2'(c));
    s1 = 0;
    for (int c = 0; c < NCHAN; c++) s1 += obs_cnt[c];
    chk("post_reset_no_int", 32'(s1 - s0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
